// File: rtl/fir_arb_pkg.sv
// Shared types and constants for the frame-granular FIR arbiter.
package fir_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } arb_state_e;

  localparam int unsigned FIR_TAPS        = 15;
  localparam int unsigned DEFAULT_TIMEOUT = 4096;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin find-first: first requester after 'last', with wrap.
module rr_picker #(
  parameter  int unsigned NUM_SRC = 4,
  localparam int unsigned ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_valid
);

  logic [ID_W-1:0] idx;

  // Scan farthest-to-nearest so the nearest requester after 'last' is written last and wins.
  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int unsigned i = NUM_SRC; i >= 1; i--) begin
      idx = ID_W'((32'(last) + i) % NUM_SRC);
      if (req[idx]) begin
        gnt_id    = idx;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one FIR between NUM_SRC AXI-Stream
// sources; the next grant waits for the FIR's own output tlast (or a timeout).
module fir_frame_arbiter
  import fir_arb_pkg::*;
#(
  parameter  int unsigned NUM_SRC                = 4,
  parameter  int unsigned C_S00_AXIS_TDATA_WIDTH = 32,
  parameter  int unsigned C_M00_AXIS_TDATA_WIDTH = 32,
  parameter  int unsigned TIMEOUT_CYCLES         = DEFAULT_TIMEOUT,
  localparam int unsigned ID_W                   = $clog2(NUM_SRC)
) (
  input  logic                                        s00_axis_aclk,
  input  logic                                        s00_axis_aresetn,
  input  logic [NUM_SRC*C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [NUM_SRC*C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic [NUM_SRC-1:0]                          s00_axis_tvalid,
  input  logic [NUM_SRC-1:0]                          s00_axis_tlast,
  output logic [NUM_SRC-1:0]                          s00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]           m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]         m00_axis_tstrb,
  output logic                                        m00_axis_tvalid,
  output logic                                        m00_axis_tlast,
  input  logic                                        m00_axis_tready,
  output logic [ID_W-1:0]                             m00_axis_tuser,
  input  logic                                        fir_mon_tvalid,
  input  logic                                        fir_mon_tready,
  input  logic                                        fir_mon_tlast,
  output logic [ID_W-1:0]                             out_id,
  output logic                                        busy,
  output logic                                        timeout_err
);

  localparam int unsigned DW = C_S00_AXIS_TDATA_WIDTH;
  localparam int unsigned SW = C_S00_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  arb_state_e      state_q, state_d;
  logic [ID_W-1:0] grant_q, grant_d;
  logic [ID_W-1:0] last_q,  last_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tmo_q,   tmo_d;

  logic [ID_W-1:0] pick_id;
  logic            pick_valid;
  logic            streaming;
  logic            ret_last;

  rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req       (s00_axis_tvalid),
    .last      (last_q),
    .gnt_id    (pick_id),
    .gnt_valid (pick_valid)
  );

  assign streaming = (state_q == ST_STREAM);
  assign ret_last  = fir_mon_tvalid & fir_mon_tready & fir_mon_tlast;

  // Zero-latency datapath: data/strb follow the grant, valid/last only while streaming.
  assign m00_axis_tdata  = s00_axis_tdata[grant_q*DW +: DW];
  assign m00_axis_tstrb  = s00_axis_tstrb[grant_q*SW +: SW];
  assign m00_axis_tvalid = streaming & s00_axis_tvalid[grant_q];
  assign m00_axis_tlast  = streaming & s00_axis_tlast[grant_q];

  always_comb begin
    s00_axis_tready = '0;
    if (streaming) s00_axis_tready[grant_q] = m00_axis_tready;
  end

  assign m00_axis_tuser = grant_q;
  assign out_id         = grant_q;
  assign busy           = (state_q != ST_IDLE);
  assign timeout_err    = tmo_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    timer_d = timer_q;
    tmo_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_id;
          last_d  = pick_id;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (m00_axis_tvalid & m00_axis_tready & m00_axis_tlast) begin
          state_d = ST_DRAIN;
          timer_d = '0;
        end
      end
      ST_DRAIN: begin
        timer_d = timer_q + TW'(1);
        if (ret_last) begin
          state_d = ST_IDLE;
        end else if (timer_q == T_LAST) begin
          state_d = ST_IDLE;
          tmo_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= ID_W'(NUM_SRC - 1);
      timer_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule

// File: tb/tb_fir_frame_arbiter.sv
// Directed bench for fir_frame_arbiter: per-cycle reference model plus literal scenario checks.
module tb_fir_frame_arbiter;
  import fir_arb_pkg::*;

  localparam int NS = 4;
  localparam int W  = 32;
  localparam int SW = 4;
  localparam int T  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NS*W-1:0]  s_tdata;
  logic [NS*SW-1:0] s_tstrb;
  logic [NS-1:0]    s_tvalid, s_tlast, s_tready;
  logic [W-1:0]     m_tdata;
  logic [SW-1:0]    m_tstrb;
  logic             m_tvalid, m_tlast, m_tready;
  logic [1:0]       m_tuser, out_id;
  logic             fm_v, fm_r, fm_l, busy, timeout_err;

  fir_frame_arbiter #(
    .NUM_SRC                (NS),
    .C_S00_AXIS_TDATA_WIDTH (W),
    .C_M00_AXIS_TDATA_WIDTH (W),
    .TIMEOUT_CYCLES         (T)
  ) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_tdata),
    .s00_axis_tstrb   (s_tstrb),
    .s00_axis_tvalid  (s_tvalid),
    .s00_axis_tlast   (s_tlast),
    .s00_axis_tready  (s_tready),
    .m00_axis_tdata   (m_tdata),
    .m00_axis_tstrb   (m_tstrb),
    .m00_axis_tvalid  (m_tvalid),
    .m00_axis_tlast   (m_tlast),
    .m00_axis_tready  (m_tready),
    .m00_axis_tuser   (m_tuser),
    .fir_mon_tvalid   (fm_v),
    .fir_mon_tready   (fm_r),
    .fir_mon_tlast    (fm_l),
    .out_id           (out_id),
    .busy             (busy),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  int src_len[NS], src_beat[NS], src_frame[NS], src_left[NS];
  int ret_delay, ret_at, spur_a, spur_b, rdy_lo_from, rdy_lo_to;

  logic [W+1:0] beats_q[$];
  int start_q[$], order_q[$], ret_q[$];
  int nto, to_cyc, busy_fall;
  bit in_frame, prev_busy;

  function automatic logic [W-1:0] mkdata(int k, int f, int b);
    return {8'(k), 8'(f), 16'(b)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_src();
    for (int k = 0; k < NS; k++) begin
      s_tvalid[k] = src_left[k] > 0;
      s_tlast[k]  = (src_left[k] > 0) && (src_beat[k] == src_len[k] - 1);
      s_tdata[k*W +: W]   = mkdata(k, src_frame[k], src_beat[k]);
      s_tstrb[k*SW +: SW] = 4'((src_beat[k] + k) % 16);
    end
  endtask

  task automatic start_src(input int k, input int len, input int frames);
    src_len[k] = len; src_beat[k] = 0; src_frame[k] = 0; src_left[k] = frames;
    drive_src();
  endtask

  // One clock: sample handshakes mid-cycle, then update stimulus just after the edge.
  task automatic tick();
    logic [NS-1:0] hs;
    logic mlast;
    @(negedge clk);
    hs    = s_tvalid & s_tready;
    mlast = m_tvalid & m_tready & m_tlast;
    if (mlast && ret_delay >= 0) ret_at = cyc + ret_delay;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < NS; k++) begin
      if (hs[k]) begin
        if (src_beat[k] == src_len[k] - 1) begin
          src_beat[k] = 0; src_frame[k]++; src_left[k]--;
        end else begin
          src_beat[k]++;
        end
      end
    end
    m_tready = !(cyc >= rdy_lo_from && cyc < rdy_lo_to);
    fm_v = (cyc == ret_at) || (cyc == spur_a) || (cyc == spur_b);
    fm_r = fm_v;
    fm_l = fm_v;
    if (cyc == ret_at) ret_q.push_back(cyc);
    drive_src();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    beats_q.delete(); start_q.delete(); order_q.delete(); ret_q.delete();
    nto = 0; to_cyc = -1; busy_fall = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NS; k++) src_left[k] = 0;
    ret_at = -1; spur_a = -1; spur_b = -1; rdy_lo_from = -1; rdy_lo_to = -1;
    ret_delay = FIR_TAPS - 1;
    fm_v = 1'b0; fm_r = 1'b0; fm_l = 1'b0;
    drive_src();
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
    tick();
  endtask

  // Reference model: who owns the FIR, whether we await its return, and the drain deadline.
  int mo_owner = -1;
  bit mo_drain = 1'b0;
  int mo_last  = NS - 1;
  int mo_id    = 0;
  int mo_dstart = 0;
  bit mo_to    = 1'b0;

  always @(negedge clk) begin : cmp
    logic [NS-1:0] e_ready;
    logic e_valid, e_last, active, found;
    int c;
    if (!rst_n) begin
      mo_owner = -1; mo_drain = 1'b0; mo_last = NS - 1; mo_id = 0; mo_to = 1'b0;
      in_frame = 1'b0; prev_busy = 1'b0;
      chk("rst_tready", 64'(s_tready), 64'd0);
      chk("rst_mvalid", 64'(m_tvalid), 64'd0);
      chk("rst_mlast",  64'(m_tlast),  64'd0);
      chk("rst_busy",   64'(busy),     64'd0);
      chk("rst_out_id", 64'(out_id),   64'd0);
      chk("rst_tuser",  64'(m_tuser),  64'd0);
      chk("rst_tmo",    64'(timeout_err), 64'd0);
    end else begin
      active  = (mo_owner >= 0) && !mo_drain;
      e_valid = active ? s_tvalid[mo_owner] : 1'b0;
      e_last  = active ? s_tlast[mo_owner]  : 1'b0;
      e_ready = '0;
      if (active && m_tready) e_ready[mo_owner] = 1'b1;
      chk("tready", 64'(s_tready), 64'(e_ready));
      chk("mvalid", 64'(m_tvalid), 64'(e_valid));
      chk("mlast",  64'(m_tlast),  64'(e_last));
      chk("busy",   64'(busy),     64'(mo_owner >= 0));
      chk("out_id", 64'(out_id),   64'(mo_id));
      chk("tuser",  64'(m_tuser),  64'(mo_id));
      chk("timeout_err", 64'(timeout_err), 64'(mo_to));
      if (e_valid) begin
        chk("mdata", 64'(m_tdata), 64'(s_tdata[mo_owner*W +: W]));
        chk("mstrb", 64'(m_tstrb), 64'(s_tstrb[mo_owner*SW +: SW]));
      end

      if (m_tvalid && m_tready) begin
        beats_q.push_back({m_tuser, m_tdata});
        if (!in_frame) start_q.push_back(cyc);
        in_frame = !m_tlast;
        if (m_tlast) order_q.push_back(int'(m_tuser));
      end
      if (timeout_err) begin nto++; to_cyc = cyc; end
      if (prev_busy && !busy) busy_fall = cyc;
      prev_busy = busy;

      mo_to = 1'b0;
      if (mo_owner < 0) begin
        found = 1'b0;
        for (int i = 1; i <= NS; i++) begin
          c = (mo_last + i) % NS;
          if (!found && s_tvalid[c]) begin
            found = 1'b1; mo_owner = c; mo_last = c; mo_id = c;
          end
        end
      end else if (!mo_drain) begin
        if (e_valid && m_tready && e_last) begin mo_drain = 1'b1; mo_dstart = cyc + 1; end
      end else begin
        if (fm_v && fm_r && fm_l) begin
          mo_owner = -1; mo_drain = 1'b0;
        end else if (cyc == mo_dstart + T - 1) begin
          mo_owner = -1; mo_drain = 1'b0; mo_to = 1'b1;
        end
      end
    end
  end

  int x;
  int exp_order[6] = '{0, 1, 2, 0, 1, 2};

  initial begin
    m_tready = 1'b1;
    fm_v = 1'b0; fm_r = 1'b0; fm_l = 1'b0;
    ret_at = -1; spur_a = -1; spur_b = -1; rdy_lo_from = -1; rdy_lo_to = -1;
    ret_delay = FIR_TAPS - 1;
    for (int k = 0; k < NS; k++) begin
      src_len[k] = 1; src_beat[k] = 0; src_frame[k] = 0; src_left[k] = 0;
    end
    drive_src();
    clear_logs();

    // Single source 0, 20-beat frame, return 14 cycles after its tlast.
    do_reset();
    x = cyc;
    start_src(0, 20, 1);
    run(40);
    chk("t1_beats", 64'(beats_q.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      if (i < beats_q.size()) chk("t1_data", 64'(beats_q[i]), 64'({2'd0, 32'(i)}));
    chk("t1_first", 64'(start_q.size() > 0 ? start_q[0] : -1), 64'(x + 1));
    chk("t1_ret",   64'(ret_q.size() > 0 ? ret_q[0] : -1), 64'(x + 34));
    chk("t1_busy_fall", 64'(busy_fall), 64'(x + 35));
    chk("t1_timeouts", 64'(nto), 64'd0);

    // Sources 0,1,2 continuously valid, two 8-beat frames each.
    do_reset();
    x = cyc;
    start_src(0, 8, 2);
    start_src(1, 8, 2);
    start_src(2, 8, 2);
    run(145);
    chk("t2_frames", 64'(order_q.size()), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < order_q.size()) chk("t2_order", 64'(order_q[i]), 64'(exp_order[i]));
      if (i > 0 && i < start_q.size() && i - 1 < ret_q.size())
        chk("t2_bubble", 64'(start_q[i]), 64'(ret_q[i-1] + 2));
      for (int j = 0; j < 8; j++)
        if (i*8 + j < beats_q.size())
          chk("t2_data", 64'(beats_q[i*8 + j]),
              64'({2'(exp_order[i]), mkdata(exp_order[i], i / 3, j)}));
    end
    chk("t2_first", 64'(start_q.size() > 0 ? start_q[0] : -1), 64'(x + 1));

    // Source 1, 10 beats, FIR input ready low for 5 cycles mid-frame.
    do_reset();
    x = cyc;
    start_src(1, 10, 1);
    rdy_lo_from = x + 4;
    rdy_lo_to   = x + 9;
    run(35);
    chk("t3_beats", 64'(beats_q.size()), 64'd10);
    for (int i = 0; i < 10; i++)
      if (i < beats_q.size()) chk("t3_data", 64'(beats_q[i]), 64'({2'd1, mkdata(1, 0, i)}));
    if (beats_q.size() > 3) chk("t3_beat3", 64'(beats_q[3]), 64'({2'd1, 32'h0100_0003}));
    chk("t3_ret", 64'(ret_q.size() > 0 ? ret_q[0] : -1), 64'(x + 29));

    // Return tlast never arrives: timeout after 16 DRAIN cycles, then source 3 granted.
    do_reset();
    ret_delay = -1;
    x = cyc;
    start_src(2, 4, 1);
    start_src(3, 3, 1);
    run(26);
    chk("t4_timeouts", 64'(nto), 64'd1);
    chk("t4_to_cycle", 64'(to_cyc), 64'(x + 21));
    chk("t4_next_start", 64'(start_q.size() > 1 ? start_q[1] : -1), 64'(x + 22));
    chk("t4_next_id", 64'(order_q.size() > 1 ? order_q[1] : -1), 64'd3);

    // Reset in the middle of source 3's frame; source 0 must win first afterwards.
    do_reset();
    x = cyc;
    start_src(3, 12, 1);
    run(6);
    chk("t5_beats_before", 64'(beats_q.size()), 64'd5);
    rst_n = 1'b0;
    start_src(0, 4, 1);
    #1;
    chk("t5_tready_now", 64'(s_tready), 64'd0);
    chk("t5_mvalid_now", 64'(m_tvalid), 64'd0);
    tick();
    rst_n = 1'b1;
    clear_logs();
    run(20);
    chk("t5_first_id", 64'(order_q.size() > 0 ? order_q[0] : -1), 64'd0);
    chk("t5_first_start", 64'(start_q.size() > 0 ? start_q[0] : -1), 64'(x + 8));

    // Spurious FIR tlast during STREAM (mid-frame and on the tlast beat) is ignored.
    do_reset();
    ret_delay = 10;
    x = cyc;
    start_src(1, 8, 1);
    spur_a = x + 3;
    spur_b = x + 8;
    run(25);
    chk("t6_beats", 64'(beats_q.size()), 64'd8);
    chk("t6_ret", 64'(ret_q.size() > 0 ? ret_q[0] : -1), 64'(x + 18));
    chk("t6_busy_fall", 64'(busy_fall), 64'(x + 19));
    chk("t6_timeouts", 64'(nto), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
